// File: rtl/prach_pkg.sv
// Shared widths, pair record and serializer state encoding for the PRACH lane serializer.
package prach_pkg;

    localparam int PRACH_DW = 16;
    localparam int PRACH_CW = 8;

    typedef struct packed {
        logic [PRACH_CW-1:0] chn;
        logic [PRACH_DW-1:0] dp1;
        logic [PRACH_DW-1:0] dp2;
    } prach_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LANE2 = 2'd1,
        ST_LANE1 = 2'd2
    } ser_state_t;

endpackage

// File: rtl/prach_sync_fifo.sv
// First-word-fall-through FIFO with synchronous clear; a push coincident with clear lands in the emptied FIFO.
module prach_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_q, rd_q, wr_d, rd_d;
    logic [AW-1:0] waddr;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr_i) begin
            rd_d = '0;
            wr_d = {{AW{1'b0}}, push_i};
        end else begin
            if (push_i) wr_d = wr_q + PTR_ONE;
            if (pop_i)  rd_d = rd_q + PTR_ONE;
        end
    end

    assign waddr = clr_i ? '0 : wr_q[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[waddr] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign count_o = wr_q - rd_q;
    assign empty_o = (wr_q == rd_q);
    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/prach_lane_serializer.sv
// Buffers {chn, dp1, dp2} pairs and emits them as a single sample stream, dp1 then dp2 on consecutive cycles.
// state | meaning
// IDLE  | no half in flight; load dp1 of head entry when FIFO non-empty
// LANE2 | dp1 of head just emitted; emit dp2 and pop the entry
// LANE1 | dp2 just emitted and another entry waits; emit its dp1
module prach_lane_serializer
    import prach_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = PRACH_DW,
    parameter int CW    = PRACH_CW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DW-1:0]          din_dp1,
    input  logic [DW-1:0]          din_dp2,
    input  logic                   din_dv,
    input  logic [CW-1:0]          din_chn,
    input  logic                   sync_in,
    output logic [DW-1:0]          dout_d,
    output logic                   dout_dv,
    output logic [CW-1:0]          dout_chn,
    output logic                   dout_lane,
    output logic                   sync_out,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fill
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [CW-1:0] chn;
        logic [DW-1:0] dp1;
        logic [DW-1:0] dp2;
    } pair_t;

    localparam int PW = $bits(pair_t);
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    pair_t         wpair, rpair;
    logic [PW-1:0] rdata;
    logic [AW:0]   count;
    logic          empty, full;
    logic          pop_d, push_d, drop_d, more_d;

    ser_state_t    state_q;
    logic [DW-1:0] dout_d_q;
    logic [CW-1:0] dout_chn_q;
    logic          dout_dv_q, dout_lane_q, sync_out_q, overflow_q;

    assign wpair  = '{chn: din_chn, dp1: din_dp1, dp2: din_dp2};
    assign rpair  = rdata;
    assign pop_d  = (state_q == ST_LANE2) && !sync_in;
    // A full FIFO still accepts when the head leaves this edge, and always after a clear.
    assign push_d = din_dv && (sync_in || !full || pop_d);
    assign drop_d = din_dv && !push_d;
    assign more_d = push_d || (count != CNT_ONE);

    prach_sync_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (sync_in),
        .push_i  (push_d),
        .pop_i   (pop_d),
        .wdata_i (wpair),
        .rdata_o (rdata),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dout_d_q    <= '0;
            dout_chn_q  <= '0;
            dout_dv_q   <= 1'b0;
            dout_lane_q <= 1'b0;
            sync_out_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync_out_q <= sync_in;
            if (sync_in) begin
                state_q    <= ST_IDLE;
                dout_dv_q  <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                if (drop_d) overflow_q <= 1'b1;
                case (state_q)
                    ST_IDLE, ST_LANE1: begin
                        if (!empty) begin
                            dout_d_q    <= rpair.dp1;
                            dout_chn_q  <= rpair.chn;
                            dout_lane_q <= 1'b0;
                            dout_dv_q   <= 1'b1;
                            state_q     <= ST_LANE2;
                        end else begin
                            dout_dv_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end
                    ST_LANE2: begin
                        dout_d_q    <= rpair.dp2;
                        dout_chn_q  <= rpair.chn;
                        dout_lane_q <= 1'b1;
                        dout_dv_q   <= 1'b1;
                        state_q     <= more_d ? ST_LANE1 : ST_IDLE;
                    end
                    default: begin
                        dout_dv_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign dout_d    = dout_d_q;
    assign dout_chn  = dout_chn_q;
    assign dout_dv   = dout_dv_q;
    assign dout_lane = dout_lane_q;
    assign sync_out  = sync_out_q;
    assign overflow  = overflow_q;
    assign fill      = count;

endmodule

// File: tb/tb_prach_lane_serializer.sv
// Bench for prach_lane_serializer: DEPTH=16 and DEPTH=4 instances share stimulus and are tracked by a queue model.
module tb_prach_lane_serializer;
    import prach_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din_dp1 = '0, din_dp2 = '0;
    logic        din_dv = 1'b0;
    logic [7:0]  din_chn = '0;
    logic        sync_in = 1'b0;

    logic [15:0] a_d, b_d;
    logic        a_dv, b_dv, a_lane, b_lane, a_so, b_so, a_ovf, b_ovf;
    logic [7:0]  a_chn, b_chn;
    logic [4:0]  a_fill;
    logic [2:0]  b_fill;

    always #5 clk = ~clk;

    prach_lane_serializer #(.DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .din_dp1(din_dp1), .din_dp2(din_dp2), .din_dv(din_dv),
        .din_chn(din_chn), .sync_in(sync_in), .dout_d(a_d), .dout_dv(a_dv), .dout_chn(a_chn),
        .dout_lane(a_lane), .sync_out(a_so), .overflow(a_ovf), .fill(a_fill));

    prach_lane_serializer #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din_dp1(din_dp1), .din_dp2(din_dp2), .din_dv(din_dv),
        .din_chn(din_chn), .sync_in(sync_in), .dout_d(b_d), .dout_dv(b_dv), .dout_chn(b_chn),
        .dout_lane(b_lane), .sync_out(b_so), .overflow(b_ovf), .fill(b_fill));

    int n_tests = 0, n_fail = 0;

    // Reference: per-instance list of stored pairs plus "dp1 of head already sent" flag.
    prach_pair_t m_mem [2][64];
    int          m_head [2], m_size [2], m_acc [2];
    int          m_depth [2] = '{16, 4};
    bit          m_half [2];
    logic        e_dv [2], e_lane [2], e_sync [2], e_ovf [2];
    logic [15:0] e_d [2];
    logic [7:0]  e_chn [2];
    int          dv_cnt [2];
    int          cyc = 0, first_dv = -1, last_dv = -1, max_fill = 0;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_head[m] = 0; m_size[m] = 0; m_half[m] = 0;
            e_dv[m] = 0; e_lane[m] = 0; e_sync[m] = 0; e_ovf[m] = 0; e_d[m] = '0; e_chn[m] = '0;
        end
    endtask

    task automatic model_push(input int m);
        m_mem[m][(m_head[m] + m_size[m]) % 64] = '{chn: din_chn, dp1: din_dp1, dp2: din_dp2};
        m_size[m]++;
        m_acc[m]++;
    endtask

    task automatic model_step(input int m);
        prach_pair_t h;
        bit popping;
        e_sync[m] = sync_in;
        if (sync_in) begin
            m_size[m] = 0; m_half[m] = 0; e_dv[m] = 0; e_ovf[m] = 0;
            if (din_dv) model_push(m);
        end else begin
            popping = 0;
            h = m_mem[m][m_head[m]];
            if (m_half[m]) begin
                e_dv[m] = 1; e_d[m] = h.dp2; e_chn[m] = h.chn; e_lane[m] = 1;
                popping = 1; m_half[m] = 0;
            end else if (m_size[m] > 0) begin
                e_dv[m] = 1; e_d[m] = h.dp1; e_chn[m] = h.chn; e_lane[m] = 0;
                m_half[m] = 1;
            end else begin
                e_dv[m] = 0;
            end
            if (din_dv) begin
                if (m_size[m] < m_depth[m] || popping) model_push(m);
                else e_ovf[m] = 1;
            end
            if (popping) begin
                m_head[m] = (m_head[m] + 1) % 64;
                m_size[m]--;
            end
        end
    endtask

    task automatic cmp(input int m, input logic dv, input logic [15:0] d, input logic [7:0] chn,
                       input logic lane, input logic so, input logic ov, input int fl);
        n_tests++;
        if ({dv, d, chn, lane, so, ov} !== {e_dv[m], e_d[m], e_chn[m], e_lane[m], e_sync[m], e_ovf[m]}
            || fl != m_size[m]) begin
            n_fail++;
            $display("FAIL model_dut%0d cyc=%0d: got dv=%b d=%h chn=%h lane=%b so=%b ovf=%b fill=%0d, want dv=%b d=%h chn=%h lane=%b so=%b ovf=%b fill=%0d",
                     m_depth[m], cyc, dv, d, chn, lane, so, ov, fl,
                     e_dv[m], e_d[m], e_chn[m], e_lane[m], e_sync[m], e_ovf[m], m_size[m]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        cyc++;
        cmp(0, a_dv, a_d, a_chn, a_lane, a_so, a_ovf, int'(a_fill));
        cmp(1, b_dv, b_d, b_chn, b_lane, b_so, b_ovf, int'(b_fill));
        if (a_dv) begin
            dv_cnt[0]++;
            if (first_dv < 0) first_dv = cyc;
            last_dv = cyc;
        end
        if (b_dv) dv_cnt[1]++;
        if (int'(a_fill) > max_fill) max_fill = int'(a_fill);
    endtask

    task automatic drive(input logic dv, input logic sy, input logic [7:0] chn,
                         input logic [15:0] p1, input logic [15:0] p2);
        din_dv = dv; sync_in = sy; din_chn = chn; din_dp1 = p1; din_dp2 = p2;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 8'h00, 16'h0000, 16'h0000);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic hard_reset();
        @(negedge clk);
        drive(0, 0, 8'h00, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({a_dv, a_d, a_chn, a_lane, a_so, a_ovf, a_fill} !== '0 ||
            {b_dv, b_d, b_chn, b_lane, b_so, b_ovf, b_fill} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got a=%h b=%h, want all zero",
                     {a_dv, a_d, a_chn, a_lane, a_so, a_ovf, a_fill},
                     {b_dv, b_d, b_chn, b_lane, b_so, b_ovf, b_fill});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        dv;
        logic        sy;
        logic [7:0]  chn;
        logic [15:0] p1;
        logic [15:0] p2;
        logic        x_dv;
        logic [15:0] x_d;
        logic [7:0]  x_chn;
        logic        x_lane;
        logic        x_so;
        int          x_fill;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Each row: inputs for one cycle, then DEPTH=16 outputs expected right after that edge.
        tbl[0]  = '{1, 0, 8'h03, 16'h1111, 16'h2222, 0, 16'h0000, 8'h00, 0, 0, 1};
        tbl[1]  = '{0, 0, 8'h00, 16'h0000, 16'h0000, 1, 16'h1111, 8'h03, 0, 0, 1};
        tbl[2]  = '{0, 0, 8'h00, 16'h0000, 16'h0000, 1, 16'h2222, 8'h03, 1, 0, 0};
        tbl[3]  = '{0, 0, 8'h00, 16'h0000, 16'h0000, 0, 16'h2222, 8'h03, 1, 0, 0};
        tbl[4]  = '{1, 0, 8'h05, 16'hAAAA, 16'hBBBB, 0, 16'h2222, 8'h03, 1, 0, 1};
        tbl[5]  = '{1, 0, 8'h06, 16'hCCCC, 16'hDDDD, 1, 16'hAAAA, 8'h05, 0, 0, 2};
        tbl[6]  = '{0, 1, 8'h00, 16'h0000, 16'h0000, 0, 16'hAAAA, 8'h05, 0, 1, 0};
        tbl[7]  = '{0, 0, 8'h00, 16'h0000, 16'h0000, 0, 16'hAAAA, 8'h05, 0, 0, 0};
        tbl[8]  = '{1, 1, 8'h09, 16'hABCD, 16'h1234, 0, 16'hAAAA, 8'h05, 0, 1, 1};
        tbl[9]  = '{0, 0, 8'h00, 16'h0000, 16'h0000, 1, 16'hABCD, 8'h09, 0, 0, 1};
        tbl[10] = '{0, 0, 8'h00, 16'h0000, 16'h0000, 1, 16'h1234, 8'h09, 1, 0, 0};
        tbl[11] = '{0, 0, 8'h00, 16'h0000, 16'h0000, 0, 16'h1234, 8'h09, 1, 0, 0};

        model_reset();
        hard_reset();
        idle(10);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].dv, tbl[i].sy, tbl[i].chn, tbl[i].p1, tbl[i].p2);
            cycle();
            n_tests++;
            if ({a_dv, a_d, a_chn, a_lane, a_so, a_ovf} !==
                {tbl[i].x_dv, tbl[i].x_d, tbl[i].x_chn, tbl[i].x_lane, tbl[i].x_so, 1'b0} ||
                int'(a_fill) != tbl[i].x_fill) begin
                n_fail++;
                $display("FAIL vec%0d: got dv=%b d=%h chn=%h lane=%b so=%b ovf=%b fill=%0d, want dv=%b d=%h chn=%h lane=%b so=%b ovf=0 fill=%0d",
                         i, a_dv, a_d, a_chn, a_lane, a_so, a_ovf, a_fill,
                         tbl[i].x_dv, tbl[i].x_d, tbl[i].x_chn, tbl[i].x_lane, tbl[i].x_so, tbl[i].x_fill);
            end
        end

        // Eight pairs every other cycle: one unbroken run of 16 samples, FIFO never above one pair.
        idle(3);
        dv_cnt[0] = 0; first_dv = -1; last_dv = -1; max_fill = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 8'(i), 16'(16'h1000 + i), 16'(16'h2000 + i));
            cycle();
            idle(1);
        end
        idle(4);
        n_tests++;
        if (dv_cnt[0] != 16 || last_dv - first_dv + 1 != 16 || max_fill > 1 || a_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL paced_stream: got samples=%0d span=%0d max_fill=%0d ovf=%b, want 16 16 <=1 0",
                     dv_cnt[0], last_dv - first_dv + 1, max_fill, a_ovf);
        end

        // Twelve back-to-back pairs: DEPTH=4 drops some and flags overflow, DEPTH=16 keeps all.
        hard_reset();
        idle(2);
        dv_cnt[0] = 0; dv_cnt[1] = 0; m_acc[0] = 0; m_acc[1] = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 8'(8'h40 + i), 16'(16'h3000 + i), 16'(16'h4000 + i));
            cycle();
        end
        idle(30);
        n_tests++;
        if (b_ovf !== 1'b1 || a_ovf !== 1'b0 || dv_cnt[0] != 24 || dv_cnt[1] >= 24 ||
            dv_cnt[1] != 2 * m_acc[1]) begin
            n_fail++;
            $display("FAIL burst_overflow: got ovf4=%b ovf16=%b out16=%0d out4=%0d, want 1 0 24 %0d",
                     b_ovf, a_ovf, dv_cnt[0], dv_cnt[1], 2 * m_acc[1]);
        end

        // Reset asserted while dp2 is pending: nothing from the old pair afterwards, latency 2 after release.
        drive(1, 0, 8'h44, 16'h5555, 16'h6666);
        cycle();
        idle(1);
        hard_reset();
        drive(1, 0, 8'h77, 16'h7777, 16'h8888);
        cycle();
        n_tests++;
        if (a_dv !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_t1: got dv=%b, want 0", a_dv);
        end
        idle(1);
        n_tests++;
        if (a_dv !== 1'b1 || a_d !== 16'h7777 || a_lane !== 1'b0 || a_chn !== 8'h77) begin
            n_fail++;
            $display("FAIL post_reset_t2: got dv=%b d=%h lane=%b chn=%h, want 1 7777 0 77",
                     a_dv, a_d, a_lane, a_chn);
        end
        idle(3);

        // Randomized traffic with varying load, occasional sync and one reset.
        for (int blk = 0; blk < 8; blk++) begin
            int rate;
            rate = (blk % 3 == 0) ? 90 : ((blk % 3 == 1) ? 50 : 25);
            if (blk == 5) hard_reset();
            for (int i = 0; i < 100; i++) begin
                drive(($urandom_range(0, 99) < rate), ($urandom_range(0, 99) < 3),
                      8'($urandom), 16'($urandom), 16'($urandom));
                cycle();
            end
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
